// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: datapath width, RV32I funct3
// encodings, FSM state encodings and request legality helpers.
package load_store_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic logic funct3_illegal(input logic is_store, input logic [2:0] funct3);
    if (is_store) return (funct3 > F3_W);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] ea_lo);
    case (funct3[1:0])
      2'b01:   return ea_lo[0];
      2'b10:   return (ea_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide data memory handshake. Signal names are seen from the LSU side;
// master = load/store unit, slave = data memory.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic            data_mem_valid_out;
  logic            data_mem_write_out;
  logic [XLEN-1:0] data_mem_addr_out;
  logic [XLEN-1:0] data_mem_data_out;
  logic            data_mem_ready_in;
  logic [XLEN-1:0] data_mem_data_in;

  modport master (
    output data_mem_valid_out, data_mem_write_out, data_mem_addr_out, data_mem_data_out,
    input  data_mem_ready_in, data_mem_data_in
  );

  modport slave (
    input  data_mem_valid_out, data_mem_write_out, data_mem_addr_out, data_mem_data_out,
    output data_mem_ready_in, data_mem_data_in
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: little-endian byte/halfword extraction with sign or
// zero extension for loads, and lane merge of rs2 into a read word for sub-word stores.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] mem_word,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default on entry so no path can infer a latch.
  always_comb begin
    byte_sel  = mem_word[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = mem_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = mem_word;
    endcase
  end

  always_comb begin
    merged_word = mem_word;
    case (funct3)
      F3_B:    merged_word[{lane, 3'b000} +: 8]     = store_data[7:0];
      F3_H:    merged_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-only data memory: EA generation, sub-word
// loads and read-modify-write stores. Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              lsu_req_valid_in,
  output logic              lsu_req_ready_out,
  input  logic              lsu_req_store_in,
  input  logic [2:0]        lsu_req_funct3_in,
  input  logic [XLEN-1:0]   lsu_req_base_in,
  input  logic [XLEN-1:0]   lsu_req_offset_in,
  input  logic [XLEN-1:0]   lsu_req_data_in,
  input  logic [4:0]        lsu_req_rd_in,
  output logic              lsu_resp_valid_out,
  output logic [XLEN-1:0]   lsu_resp_data_out,
  output logic [4:0]        lsu_resp_rd_out,
  output logic              lsu_resp_error_out,
  load_store_unit_if.master data_mem
);

  logic [1:0]      state_q;
  logic [XLEN-1:0] ea_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] resp_data_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            store_q;
  logic            error_q;

  logic [XLEN-1:0] req_ea;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;
  logic            req_error;

  assign req_ea = lsu_req_base_in + lsu_req_offset_in;

  always_comb begin
    req_error = funct3_illegal(lsu_req_store_in, lsu_req_funct3_in);
`ifdef LSU_MISALIGN_TRAP_EN
    if (addr_misaligned(lsu_req_funct3_in, req_ea[1:0])) req_error = 1'b1;
`endif
  end

  load_store_unit_align u_align (
    .funct3      (funct3_q),
    .lane        (ea_q[1:0]),
    .mem_word    (data_mem.data_mem_data_in),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q     <= ST_IDLE;
      ea_q        <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      store_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (lsu_req_valid_in) begin
          ea_q        <= req_ea;
          wdata_q     <= lsu_req_data_in;
          resp_data_q <= '0;
          funct3_q    <= lsu_req_funct3_in;
          rd_q        <= lsu_req_rd_in;
          store_q     <= lsu_req_store_in;
          error_q     <= req_error;
          if (req_error)                                        state_q <= ST_RESP;
          else if (lsu_req_store_in && lsu_req_funct3_in == F3_W) state_q <= ST_WRITE;
          else                                                  state_q <= ST_READ;
        end
        ST_READ: if (data_mem.data_mem_ready_in) begin
          // Sub-word stores come through here to fetch the word they patch.
          if (store_q) begin
            wdata_q <= merged_word;
            state_q <= ST_WRITE;
          end else begin
            resp_data_q <= load_data;
            state_q     <= ST_RESP;
          end
        end
        ST_WRITE: if (data_mem.data_mem_ready_in) state_q <= ST_RESP;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign lsu_req_ready_out  = (state_q == ST_IDLE);
  assign lsu_resp_valid_out = (state_q == ST_RESP);
  assign lsu_resp_data_out  = resp_data_q;
  assign lsu_resp_rd_out    = rd_q;
  assign lsu_resp_error_out = error_q;

  assign data_mem.data_mem_valid_out = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign data_mem.data_mem_write_out = (state_q == ST_WRITE);
  assign data_mem.data_mem_addr_out  = {ea_q[XLEN-1:2], 2'b00};
  assign data_mem.data_mem_data_out  = wdata_q;

endmodule
